// File: rtl/machine_timer.sv
// Machine timer peripheral: prescaled up-counter with a compare register.
// A match latches PEND, and PEND & IE drives the timer bit of the interrupt-flag
// bus sampled by the core-local interrupt controller. Registers are reached over
// a single-cycle request/ack peripheral bus.
module machine_timer #(
    parameter int          INT_W     = 8,
    parameter int          TIMER_BIT = 0,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             ack_o,
    output logic [INT_W-1:0] int_flag_o
);

    // Word offsets inside the 16-byte register window
    localparam logic [1:0] OFF_CTRL  = 2'd0;
    localparam logic [1:0] OFF_COUNT = 2'd1;
    localparam logic [1:0] OFF_VALUE = 2'd2;
    localparam logic [1:0] OFF_PRESC = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_PEND    = 2;
    localparam int CTRL_ONESHOT = 3;

    // Assemble the CTRL read view from the individual flag registers
    function automatic logic [31:0] pack_ctrl(
        input logic en,
        input logic ie,
        input logic pend,
        input logic oneshot
    );
        return {28'd0, oneshot, pend, ie, en};
    endfunction

    // Architectural state
    logic             r_en;
    logic             r_ie;
    logic             r_pend;
    logic             r_oneshot;
    logic [31:0]      r_count;
    logic [31:0]      r_value;
    logic [15:0]      r_prescale;
    logic [15:0]      r_presc_cnt;

    // Registered bus and interrupt outputs
    logic             r_ack;
    logic [31:0]      r_rdata;
    logic [INT_W-1:0] r_int_flag;

    // Bus decode
    logic             w_sel;
    logic [1:0]       w_off;
    logic             w_rd;
    logic             w_wr_ctrl;
    logic             w_wr_count;
    logic             w_wr_value;
    logic             w_wr_presc;
    logic [31:0]      w_rd_data;

    // Timer datapath
    logic             w_tick;
    logic             w_match;
    logic             w_en_nxt;
    logic             w_ie_nxt;
    logic             w_pend_nxt;
    logic             w_oneshot_nxt;
    logic [31:0]      w_count_nxt;
    logic [31:0]      w_value_nxt;
    logic [15:0]      w_prescale_nxt;
    logic [15:0]      w_presc_cnt_nxt;
    logic [31:0]      w_rdata_nxt;
    logic [INT_W-1:0] w_int_flag_nxt;

    // Address decode: window match on bits 31:4, word select on 3:2.
    // The byte-lane bits 1:0 are masked out so they can never affect decode.
    always_comb begin
        w_sel      = req_i
                     && (addr_i[31:4] == BASE_ADDR[31:4])
                     && ((addr_i[1:0] & 2'b00) == 2'b00);
        w_off      = addr_i[3:2];
        w_rd       = w_sel && !we_i;
        w_wr_ctrl  = w_sel && we_i && (w_off == OFF_CTRL);
        w_wr_count = w_sel && we_i && (w_off == OFF_COUNT);
        w_wr_value = w_sel && we_i && (w_off == OFF_VALUE);
        w_wr_presc = w_sel && we_i && (w_off == OFF_PRESC);
    end

    // Read mux over the register state as it stands in the request cycle
    always_comb begin
        w_rd_data = 32'd0;
        case (w_off)
            OFF_CTRL:  w_rd_data = pack_ctrl(r_en, r_ie, r_pend, r_oneshot);
            OFF_COUNT: w_rd_data = r_count;
            OFF_VALUE: w_rd_data = r_value;
            OFF_PRESC: w_rd_data = {16'd0, r_prescale};
            default:   w_rd_data = 32'd0;
        endcase
    end

    // Prescaler tick and compare match
    always_comb begin
        w_tick  = r_en && (r_presc_cnt == r_prescale);
        w_match = w_tick && (r_count >= r_value);
    end

    // Prescaler counter: restarts on a PRESCALE write, parked at 0 while disabled
    always_comb begin
        w_presc_cnt_nxt = r_presc_cnt;
        if (w_wr_presc) begin
            w_presc_cnt_nxt = 16'd0;
        end else if (!r_en) begin
            w_presc_cnt_nxt = 16'd0;
        end else if (w_tick) begin
            w_presc_cnt_nxt = 16'd0;
        end else begin
            w_presc_cnt_nxt = r_presc_cnt + 16'd1;
        end
    end

    // Main counter: a software write overrides whatever the tick would do
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_count) begin
            w_count_nxt = wdata_i;
        end else if (w_match) begin
            w_count_nxt = 32'd0;
        end else if (w_tick) begin
            w_count_nxt = r_count + 32'd1;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Compare and prescale value registers
    always_comb begin
        w_value_nxt    = r_value;
        w_prescale_nxt = r_prescale;
        if (w_wr_value) begin
            w_value_nxt = wdata_i;
        end else begin
            w_value_nxt = r_value;
        end
        if (w_wr_presc) begin
            w_prescale_nxt = wdata_i[15:0];
        end else begin
            w_prescale_nxt = r_prescale;
        end
    end

    // CTRL flags: hardware events (match set of PEND, one-shot clear of EN) beat software
    always_comb begin
        w_en_nxt      = r_en;
        w_ie_nxt      = r_ie;
        w_oneshot_nxt = r_oneshot;
        w_pend_nxt    = r_pend;

        if (w_match && r_oneshot) begin
            w_en_nxt = 1'b0;
        end else if (w_wr_ctrl) begin
            w_en_nxt = wdata_i[CTRL_EN];
        end else begin
            w_en_nxt = r_en;
        end

        if (w_wr_ctrl) begin
            w_ie_nxt      = wdata_i[CTRL_IE];
            w_oneshot_nxt = wdata_i[CTRL_ONESHOT];
        end else begin
            w_ie_nxt      = r_ie;
            w_oneshot_nxt = r_oneshot;
        end

        if (w_match) begin
            w_pend_nxt = 1'b1;
        end else if (w_wr_ctrl && wdata_i[CTRL_PEND]) begin
            w_pend_nxt = 1'b0;
        end else begin
            w_pend_nxt = r_pend;
        end
    end

    // Output next-state: read data only on read acks, level interrupt from PEND & IE
    always_comb begin
        w_int_flag_nxt            = {INT_W{1'b0}};
        w_int_flag_nxt[TIMER_BIT] = r_pend & r_ie;
        if (w_rd) begin
            w_rdata_nxt = w_rd_data;
        end else begin
            w_rdata_nxt = 32'd0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_en        <= 1'b0;
            r_ie        <= 1'b0;
            r_pend      <= 1'b0;
            r_oneshot   <= 1'b0;
            r_count     <= 32'd0;
            r_value     <= 32'd0;
            r_prescale  <= 16'd0;
            r_presc_cnt <= 16'd0;
        end else begin
            r_en        <= w_en_nxt;
            r_ie        <= w_ie_nxt;
            r_pend      <= w_pend_nxt;
            r_oneshot   <= w_oneshot_nxt;
            r_count     <= w_count_nxt;
            r_value     <= w_value_nxt;
            r_prescale  <= w_prescale_nxt;
            r_presc_cnt <= w_presc_cnt_nxt;
        end
    end

    // Bus response and interrupt output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ack      <= 1'b0;
            r_rdata    <= 32'd0;
            r_int_flag <= {INT_W{1'b0}};
        end else begin
            r_ack      <= w_sel;
            r_rdata    <= w_rdata_nxt;
            r_int_flag <= w_int_flag_nxt;
        end
    end

    assign ack_o      = r_ack;
    assign rdata_o    = r_rdata;
    assign int_flag_o = r_int_flag;

endmodule
